float_to_int_serial: RTL and testbench

Sequential IEEE-754 single-precision to signed 32-bit integer converter that sits directly downstream of the floating-point adder and consumes its `result` word. It uses one iterative shift per clock with a valid/ready handshake on both sides, so FPU results can be handed to integer datapaths and displays without a 32-bit barrel shifter. The block raises overflow, invalid and inexact flags alongside each converted value.

---
 rtl/float_to_int_serial_if.sv | 16 +
 rtl/float_to_int_serial.sv | 101 ++++++++++
 tb/tb_float_to_int_serial.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/float_to_int_serial_if.sv
// float_to_int_serial_if: valid/ready bundle between a float producer, the converter and an integer consumer
//   in_valid, fp_in   : operand offered by the producer (master)
//   in_ready          : converter can take an operand
//   out_valid         : int_out and flags hold a result until out_ready
//   out_ready         : consumer takes the result (master)
//   int_out           : signed two's-complement result
//   overflow, invalid, inexact : result flags
interface float_to_int_serial_if #(parameter int XLEN = 32);
    logic            in_valid, in_ready, out_valid, out_ready;
    logic            overflow, invalid, inexact;
    logic [XLEN-1:0] fp_in, int_out;
    modport master (output in_valid, fp_in, out_ready,
                    input  in_ready, out_valid, int_out, overflow, invalid, inexact);
    modport slave  (input  in_valid, fp_in, out_ready,
                    output in_ready, out_valid, int_out, overflow, invalid, inexact);
endinterface

// File: rtl/float_to_int_serial.sv
// float_to_int_serial: IEEE-754 single to signed 32-bit integer, one shift per clock
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : float_to_int_serial_if.slave (operand in, result + overflow/invalid/inexact out)
//   FTOI_ROUND_NEAREST_EN : define for round-to-nearest-even, otherwise truncate toward zero
module float_to_int_serial (
    input  logic clk,
    input  logic rst,
    float_to_int_serial_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN, DONE} state_t;
    state_t      state;
    logic        s, left, sign, dir, guard, sticky, ovf, inv;
    logic [7:0]  ex;
    logic [22:0] fr;
    logic [4:0]  n, cnt;
    logic [31:0] mag, rnd, res, sat;
    assign s    = bus.fp_in[31];
    assign ex   = bus.fp_in[30:23];
    assign fr   = bus.fp_in[22:0];
    // the hidden-one mantissa sits at bit 23, so exponent 150 needs no shift
    assign left = ex >= 8'd150;
    assign n    = left ? 5'(ex - 8'd150) : 5'(8'd150 - ex);
    assign sat  = s ? 32'h8000_0000 : 32'h7fff_ffff;
    assign bus.in_ready = state == IDLE;
`ifdef FTOI_ROUND_NEAREST_EN
    assign rnd = mag + {31'b0, guard & (sticky | mag[0])};
`else
    assign rnd = mag;
`endif
    assign res = sign ? -rnd : rnd;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sign          <= 1'b0;
            dir           <= 1'b0;
            guard         <= 1'b0;
            sticky        <= 1'b0;
            ovf           <= 1'b0;
            inv           <= 1'b0;
            cnt           <= 5'd0;
            mag           <= 32'd0;
            bus.out_valid <= 1'b0;
            bus.int_out   <= 32'd0;
            bus.overflow  <= 1'b0;
            bus.invalid   <= 1'b0;
            bus.inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    // specials preload the final word in mag with sign cleared so FIN passes it through
                    ovf    <= 1'b0;
                    inv    <= 1'b0;
                    guard  <= 1'b0;
                    sticky <= 1'b0;
                    sign   <= 1'b0;
                    dir    <= left;
                    cnt    <= n;
                    state  <= FIN;
                    if (ex == 8'hff && fr != 23'd0) begin
                        mag <= 32'h8000_0000;
                        inv <= 1'b1;
                    end else if (s && ex == 8'd158 && fr == 23'd0) begin
                        mag <= 32'h8000_0000;
                    end else if (ex >= 8'd158) begin
                        mag <= sat;
                        ovf <= 1'b1;
                    end else if (ex < 8'd127) begin
                        // 0.5 <= |x| < 1 becomes guard=1 so the rounding path can lift it to 1
                        mag    <= 32'd0;
                        sign   <= s;
                        guard  <= ex == 8'd126;
                        sticky <= ex == 8'd126 ? fr != 23'd0 : (ex != 8'd0 || fr != 23'd0);
                    end else begin
                        mag  <= {9'd1, fr};
                        sign <= s;
                        if (n != 5'd0) state <= SHIFT;
                    end
                end
                SHIFT: begin
                    mag    <= dir ? mag << 1 : mag >> 1;
                    guard  <= dir ? 1'b0 : mag[0];
                    sticky <= sticky | guard;
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd1) state <= FIN;
                end
                FIN: begin
                    bus.int_out   <= res;
                    bus.overflow  <= ovf;
                    bus.invalid   <= inv;
                    bus.inexact   <= guard | sticky;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_float_to_int_serial.sv
// tb_float_to_int_serial: scoreboard bench for float_to_int_serial against a real-arithmetic model
module tb_float_to_int_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   bp = 0;
    typedef struct {
        logic [31:0] v;
        logic        o, i, x;
        int          at;
    } exp_t;
    exp_t q[$];

    float_to_int_serial_if bus ();
    float_to_int_serial dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d results pending", q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // exact value of the float as a real, then truncate / round by plain arithmetic
    function automatic exp_t model(input logic [31:0] x);
        exp_t r;
        int   ex = int'(x[30:23]);
        int   fr = int'(x[22:0]);
        real  m, f;
        int   t;
        r.o = 1'b0; r.i = 1'b0; r.x = 1'b0; r.at = 1; r.v = 32'd0;
        if (ex == 255 && fr != 0) begin
            r.v = 32'h8000_0000; r.i = 1'b1;
            return r;
        end
        m = (ex == 0) ? fr * 2.0 ** (-149) : (fr + 8388608.0) * 2.0 ** (ex - 150);
        if (ex == 255 || m >= 2147483648.0) begin
            if (x[31] && ex != 255 && m == 2147483648.0) r.v = 32'h8000_0000;
            else begin
                r.o = 1'b1;
                r.v = x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
            end
            return r;
        end
        t = $rtoi(m);
        f = m - t;
        r.x = f != 0.0;
`ifdef FTOI_ROUND_NEAREST_EN
        if (f > 0.5 || (f == 0.5 && t[0])) t++;
`endif
        r.v = x[31] ? -t : t;
        if (ex >= 127) r.at = ((ex - 127 - 23) < 0 ? 23 - (ex - 127) : ex - 127 - 23) + 1;
        return r;
    endfunction

    // called at a negedge; holds in_valid until the DUT shows in_ready
    task automatic send(input logic [31:0] x, input bit push);
        int   n = 0;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.fp_in    = x;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: operand %h not accepted, in_ready=%b", x, bus.in_ready);
        end else if (push) begin
            e = model(x);
            e.at = cyc + 1 + e.at;
            q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results pending, need 0", q.size());
        end
    endtask

    initial begin : monitor
        int   pend = 0;
        int   taken = 0;
        int   hold = 0;
        exp_t e;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                taken = 0;
                continue;
            end
            if (taken != 0) begin
                chk("idle_after_take", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
                taken = 0;
            end
            if (bus.out_valid) begin
                chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
                if (pend == 0) begin
                    pend = 1;
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got %h, expected no result", bus.int_out);
                        e.v = bus.int_out; e.o = bus.overflow; e.i = bus.invalid; e.x = bus.inexact;
                    end else begin
                        e = q.pop_front();
                        chk("int_out", bus.int_out, e.v);
                        chk("flags_oix", {29'd0, bus.overflow, bus.invalid, bus.inexact}, {29'd0, e.o, e.i, e.x});
                        chk("latency_cycle", cyc, e.at);
                    end
                    hold = bp;
                    bp = 0;
                end else begin
                    chk("stable_int_out", bus.int_out, e.v);
                    chk("stable_flags", {29'd0, bus.overflow, bus.invalid, bus.inexact}, {29'd0, e.o, e.i, e.x});
                end
                if (hold > 1) begin
                    bus.out_ready = 1'b0;
                    hold--;
                end else if (hold == 1) begin
                    bus.out_ready = 1'b1;
                    hold = 0;
                end else bus.out_ready = $urandom_range(0, 3) != 0;
                if (bus.out_ready) begin
                    pend = 0;
                    taken = 1;
                end
            end else bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : stim
        logic [31:0] dir_ops [11] = '{32'h3F95C28F, 32'hC1000000, 32'h40600000, 32'h40200000,
                                      32'h3F000000, 32'h3F400000, 32'h7F800000, 32'hFF800000,
                                      32'h7FC00000, 32'hCF000000, 32'h4F000000};
        logic [31:0] x;
        bus.in_valid = 1'b0;
        bus.fp_in    = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_int_out", bus.int_out, 32'd0);
        chk("reset_flags", {29'd0, bus.overflow, bus.invalid, bus.inexact}, 32'd0);
        chk("reset_handshake", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        rst = 1'b0;
        @(negedge clk);
        foreach (dir_ops[k]) send(dir_ops[k], 1'b1);
        drain();
        // 123.0 stalled for 10 cycles while 2^30 is already offered
        bp = 11;
        send(32'h42F60000, 1'b1);
        send(32'h4E800000, 1'b1);
        drain();
        // reset in the middle of a 1.0 conversion
        send(32'h3F800000, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_int_out", bus.int_out, 32'd0);
        chk("midreset_flags", {29'd0, bus.overflow, bus.invalid, bus.inexact}, 32'd0);
        chk("midreset_handshake", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        send(32'h41200000, 1'b1);
        drain();
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) x = $urandom;
            else x = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 160)), 23'($urandom)};
            send(x, 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
